// File: rtl/du_tx_arbiter.sv
// du_tx_arbiter: round-robin owner of the debug-unit UART Tx FIFO write port.
// A requester holds the port for a whole frame and releases it with a last
// byte, by dropping its request, or when an idle grant times out.
module du_tx_arbiter #(
  parameter int unsigned NB_UART_DATA = 8,
  parameter int unsigned NB_TIMEOUT = 16,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYCLES = NB_TIMEOUT'(1023),
  localparam int unsigned N_REQ = 3
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_wr,
  input  logic [N_REQ-1:0]              i_last,
  input  logic [N_REQ*NB_UART_DATA-1:0] i_wdata,
  input  logic                          i_tx_full,
  output logic [N_REQ-1:0]              o_gnt,
  output logic [N_REQ-1:0]              o_ready,
  output logic                          o_wr,
  output logic [NB_UART_DATA-1:0]       o_wdata,
  output logic                          o_tx_start,
  output logic                          o_timeout,
  output logic                          o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [NB_TIMEOUT-1:0]   cnt_q, cnt_d;
  logic                    wrote_q, wrote_d;
  logic [1:0]              rr_q, rr_d;
  logic                    timeout_q, timeout_d;
  logic                    tx_start_q, tx_start_d;
  logic                    busy_q;

  logic                    req_g, wr_g, last_g;
  logic                    accept, timeout_hit, release_c;
  logic [N_REQ-1:0]        pick_gnt;
  logic [NB_UART_DATA-1:0] byte_g;

  // Granted requester's controls, reduced through the one-hot grant
  always_comb begin
    req_g  = |(gnt_q & i_req);
    wr_g   = |(gnt_q & i_wr);
    last_g = |(gnt_q & i_last);
    byte_g = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (gnt_q[k]) byte_g = i_wdata[k*NB_UART_DATA +: NB_UART_DATA];
    end
    accept      = (state_q == ST_GRANT) & req_g & wr_g & ~i_tx_full;
    timeout_hit = (state_q == ST_GRANT) & req_g & ~accept & (cnt_q == TIMEOUT_CYCLES);
    release_c   = (accept & last_g) | ~req_g | timeout_hit;
  end

  // First requesting index at or after the round-robin pointer
  always_comb begin
    pick_gnt = '0;
    case (rr_q)
      2'd1:    pick_gnt = i_req[1] ? 3'b010 : (i_req[2] ? 3'b100 : 3'b001);
      2'd2:    pick_gnt = i_req[2] ? 3'b100 : (i_req[0] ? 3'b001 : 3'b010);
      default: pick_gnt = i_req[0] ? 3'b001 : (i_req[1] ? 3'b010 : 3'b100);
    endcase
  end

  // State and frame-bookkeeping registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      cnt_q      <= '0;
      wrote_q    <= 1'b0;
      rr_q       <= 2'd0;
      timeout_q  <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      wrote_q    <= wrote_d;
      rr_q       <= rr_d;
      timeout_q  <= timeout_d;
      tx_start_q <= tx_start_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Next state plus next grant, counter, pointer and end-of-frame pulses
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    wrote_d    = wrote_q;
    rr_d       = rr_q;
    timeout_d  = 1'b0;
    tx_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          state_d = ST_GRANT;
          gnt_d   = pick_gnt;
          cnt_d   = '0;
          wrote_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          wrote_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + NB_TIMEOUT'(1);
        end
        if (release_c) begin
          state_d    = ST_RELEASE;
          gnt_d      = '0;
          cnt_d      = '0;
          tx_start_d = wrote_q | accept;
          timeout_d  = timeout_hit;
          rr_d       = gnt_q[0] ? 2'd1 : (gnt_q[1] ? 2'd2 : 2'd0);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Combinational byte path from the granted requester to the FIFO
  always_comb begin
    o_wr    = accept;
    o_wdata = accept ? byte_g : '0;
    o_ready = gnt_q & i_req & {N_REQ{~i_tx_full}};
  end

  assign o_gnt      = gnt_q;
  assign o_tx_start = tx_start_q;
  assign o_timeout  = timeout_q;
  assign o_busy     = busy_q;

endmodule

// File: doc/du_tx_arbiter.md
# du_tx_arbiter

Round-robin arbiter that shares the single debug-unit UART Tx FIFO write port between three requesters: the debug master (status/handshake bytes), the register-dump sender and the data-memory-dump sender. A requester is granted the port for a whole frame, streams bytes through it under FIFO backpressure, and releases it with a last-byte flag, by dropping its request, or by timeout. At each frame end the arbiter pulses the UART transmit-start strobe. It sits between the debug-unit clients and the UART Tx FIFO.

## Interface
- NB_UART_DATA, 8, width of one UART byte
- NB_TIMEOUT, 16, width of the idle-grant timeout counter
- TIMEOUT_CYCLES, 16'd1023, idle cycles in GRANT before the grant is revoked

- clk  in  1  system clock, rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_req  in  3  per-requester frame request (bit 0 master, 1 regs sender, 2 dmem sender)
- i_wr  in  3  per-requester byte-valid
- i_last  in  3  per-requester last-byte-of-frame flag, qualified by i_wr
- i_wdata  in  3*NB_UART_DATA  packed bytes; requester k at [k*NB_UART_DATA +: NB_UART_DATA]
- i_tx_full  in  1  FIFO cannot accept a write this cycle
- o_gnt  out  3  one-hot grant, registered
- o_ready  out  3  byte accepted this cycle: o_gnt[k] & i_req[k] & ~i_tx_full
- o_wr  out  1  FIFO write enable
- o_wdata  out  NB_UART_DATA  FIFO write data
- o_tx_start  out  1  one-cycle pulse at the end of a frame that wrote at least one byte
- o_timeout  out  1  one-cycle pulse when a grant is revoked by timeout
- o_busy  out  1  high in GRANT and RELEASE

## Operation
- States: IDLE, GRANT, RELEASE. Reset: IDLE, rr_ptr=0, grant=0, timeout counter=0, wrote_any=0.
- Reset values: o_gnt=0, o_ready=0, o_wr=0, o_wdata=0, o_tx_start=0, o_timeout=0, o_busy=0.
- IDLE: if any i_req bit is set, select the first requester at or after rr_ptr (order rr_ptr, rr_ptr+1, rr_ptr+2, mod 3). Register its one-hot grant, clear the counter and wrote_any, then go to GRANT. With no request, stay in IDLE.
- GRANT, with g the granted index:
  - accept = i_req[g] & i_wr[g] & ~i_tx_full.
  - o_wr = accept; o_wdata = byte g when accept, else 0.
  - On accept: set wrote_any and clear the counter. Otherwise the counter increments.
  - Exit to RELEASE on any of: accept & i_last[g]; i_req[g] low; counter == TIMEOUT_CYCLES without accept (also pulse o_timeout).
- RELEASE: o_gnt=0; o_tx_start = wrote_any; rr_ptr = (g+1) mod 3 with 2 wrapping to 0; next state IDLE.
- Ungranted requesters' i_wr/i_wdata are ignored. o_ready to them is 0.
- Write with i_req[g] low in the same cycle: not accepted; the grant is released.

## Timing
- o_gnt asserts 1 cycle after i_req is sampled in IDLE.
- Byte path is combinational from the granted requester to o_wr/o_wdata, so the byte is written in its own cycle.
- Back-to-back frames: minimum 2 non-grant cycles (RELEASE, IDLE) between grants.
- i_tx_full high: the byte is held, o_ready=0, and i_last is not consumed. The frame continues when full drops.
- Full held high counts toward the timeout, because no accept occurs.
- Accept and timeout in the same cycle: the accept wins, the counter is cleared and there is no o_timeout.
- Async reset mid-frame: all outputs drop immediately, the FSM goes to IDLE, and rr_ptr goes to 0. A partially written frame stays in the FIFO; o_tx_start is not issued.
- Counter arithmetic is NB_TIMEOUT-bit unsigned with no wrap. The compare triggers exactly at TIMEOUT_CYCLES.

## Test plan
- Single frame: req[1]=1, write bytes 0xA0,0xA1,0xA2 with last on 0xA2 → o_wr ×3 with the same data; o_tx_start pulse 1 cycle after 0xA2; o_gnt=3'b010 then 0.
- Round-robin: i_req=3'b111 held, each requester sends a 1-byte frame with last → grant order 001, 010, 100, 001; 2 idle cycles between grants.
- Backpressure: grant 0, i_tx_full=1 for 5 cycles with byte 0x15 and last=1 → no o_wr while full; single write of 0x15 when full drops; then RELEASE.
- Timeout, TIMEOUT_CYCLES=8: req[2] held, no writes → o_timeout pulse after 9 GRANT cycles; o_tx_start stays 0; next grant goes to requester 0.
- Request drop: req[0] high, 2 bytes written, req[0] dropped without last → RELEASE; o_tx_start=1.
- Async reset: assert i_rst_n=0 mid-frame between clock edges → o_gnt and o_wr go to 0 without waiting for a clock edge; after release, i_req=3'b100 → grant 3'b100 (rr_ptr 0, first set bit).
